// File: rtl/pl_hazard_ctrl_pkg.sv
// pl_hazard_pkg: shared state encoding, widths and helpers for the pipeline hazard controller
package pl_hazard_pkg;

   typedef enum logic [1:0] {RUN, MC_WAIT, MEM_WAIT} state_t;

   localparam int MC_CNT_W  = 4;
   localparam int REG_W_DEF = 5;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
   endfunction

endpackage

// File: rtl/pl_hazard_ctrl_if.sv
// pl_hazard_ctrl_if: stage fields in, per-stage stall/bubble/flush strobes out (perf counters when HAZ_PERF_CNT_EN)
interface pl_hazard_ctrl_if
   import pl_hazard_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
) ();

   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [REG_W-1:0] ex_rd;
   logic             ex_mem_read;
   logic             ex_mc_start;
   logic             ex_branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             pc_stall;
   logic             ifid_stall;
   logic             ifid_flush;
   logic             idex_stall;
   logic             idex_bubble;
   logic             exmem_stall;
   logic             exmem_bubble;
   logic             memwb_bubble;
   logic             busy;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0]      perf_lu;
   logic [31:0]      perf_mc;
   logic [31:0]      perf_mem;
   logic [31:0]      perf_flush;
`endif

   // hazard controller side: drives the strobes
   modport master (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_mc_start, ex_branch_taken, mem_req, mem_ready,
      output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
             exmem_stall, exmem_bubble, memwb_bubble, busy
`ifdef HAZ_PERF_CNT_EN
      , output perf_lu, perf_mc, perf_mem, perf_flush
`endif
   );

   // pipeline side: supplies stage fields, consumes the strobes
   modport slave (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_mc_start, ex_branch_taken, mem_req, mem_ready,
      input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
             exmem_stall, exmem_bubble, memwb_bubble, busy
`ifdef HAZ_PERF_CNT_EN
      , input perf_lu, perf_mc, perf_mem, perf_flush
`endif
   );

endinterface

// File: rtl/pl_hazard_ctrl_stall_cnt.sv
// pl_stall_cnt: loadable down-counter with hold, flags the last stall cycle of a multi-cycle op
module pl_stall_cnt
   import pl_hazard_pkg::*;
#(
   parameter int W = MC_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   input  logic         i_dec,
   output logic         o_last
);

   logic [W-1:0] r_cnt;

   // load wins over decrement; without i_dec the count is held
   always_ff @(posedge clk or posedge rst)
      if (rst) r_cnt <= '0;
      else if (i_load) r_cnt <= i_val;
      else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - W'(1);

   assign o_last = r_cnt == W'(1);

endmodule

// File: rtl/pl_hazard_ctrl.sv
// pl_hazard_ctrl: Mealy stall/bubble/flush generator for a 5-stage pipeline; optional HAZ_PERF_CNT_EN adds event counters
module pl_hazard_ctrl
   import pl_hazard_pkg::*;
#(
   parameter int MC_LAT = 4,
   parameter int REG_W  = REG_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   pl_hazard_ctrl_if.master hz
);

   state_t           r_state, w_next;
   logic             r_pend, w_pend_nxt;
   logic             w_mem, w_mc, w_fl, w_lu;
   logic             w_load, w_dec, w_last;
   logic             w_mwait, w_lu_hit;
   logic [REG_W-1:0] w_rd;

   assign w_rd     = hz.ex_rd;
   assign w_mwait  = hz.mem_req && !hz.mem_ready;
   assign w_lu_hit = hz.ex_mem_read && w_rd != REG_W'(0) &&
                     ((hz.id_use_rs1 && hz.id_rs1 == w_rd) || (hz.id_use_rs2 && hz.id_rs2 == w_rd));

   pl_stall_cnt #(.W(MC_CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_val  (MC_CNT_W'(MC_LAT - 1)),
      .i_dec  (w_dec),
      .o_last (w_last)
   );

   // select exactly one active hazard class per cycle and the next state
   always_comb begin
      w_mem      = 1'b0;
      w_mc       = 1'b0;
      w_fl       = 1'b0;
      w_lu       = 1'b0;
      w_load     = 1'b0;
      w_dec      = 1'b0;
      w_next     = r_state;
      w_pend_nxt = r_pend;
      case (r_state)
         RUN: begin
            if (w_mwait) begin
               w_mem      = 1'b1;
               w_next     = MEM_WAIT;
               w_pend_nxt = hz.ex_branch_taken;
            end else if (hz.ex_mc_start) begin
               w_mc   = 1'b1;
               w_load = MC_LAT > 1;
               w_next = MC_LAT > 1 ? MC_WAIT : RUN;
            end else if (hz.ex_branch_taken) w_fl = 1'b1;
            else w_lu = w_lu_hit;
         end
         MC_WAIT: begin
            if (w_mwait) w_mem = 1'b1;
            else begin
               w_mc   = 1'b1;
               w_dec  = 1'b1;
               w_next = w_last ? RUN : MC_WAIT;
            end
         end
         MEM_WAIT: begin
            if (!hz.mem_ready) begin
               w_mem      = 1'b1;
               w_pend_nxt = r_pend || hz.ex_branch_taken;
            end else begin
               w_fl       = r_pend || hz.ex_branch_taken;
               w_pend_nxt = 1'b0;
               w_next     = RUN;
            end
         end
         default: w_next = RUN;
      endcase
   end

   // state and deferred-flush registers; reset drops any stall in progress
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= RUN;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_pend  <= w_pend_nxt;
      end

   // a clear of a stage always beats a hold of the same stage
   assign hz.pc_stall     = w_mem || w_mc || w_lu;
   assign hz.ifid_flush   = w_fl;
   assign hz.ifid_stall   = (w_mem || w_mc || w_lu) && !hz.ifid_flush;
   assign hz.idex_bubble  = w_fl || w_lu;
   assign hz.idex_stall   = (w_mem || w_mc) && !hz.idex_bubble;
   assign hz.exmem_bubble = w_mc;
   assign hz.exmem_stall  = w_mem && !hz.exmem_bubble;
   assign hz.memwb_bubble = w_mem;
   assign hz.busy         = r_state != RUN;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] r_perf_lu, r_perf_mc, r_perf_mem, r_perf_flush;

   // saturating per-class cycle counters
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_perf_lu    <= '0;
         r_perf_mc    <= '0;
         r_perf_mem   <= '0;
         r_perf_flush <= '0;
      end else begin
         r_perf_lu    <= sat_inc(r_perf_lu, w_lu);
         r_perf_mc    <= sat_inc(r_perf_mc, w_mc);
         r_perf_mem   <= sat_inc(r_perf_mem, w_mem);
         r_perf_flush <= sat_inc(r_perf_flush, w_fl);
      end

   assign hz.perf_lu    = r_perf_lu;
   assign hz.perf_mc    = r_perf_mc;
   assign hz.perf_mem   = r_perf_mem;
   assign hz.perf_flush = r_perf_flush;
`endif

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// tb_pl_hazard_ctrl: vector table, corner sequences and randomized model check for pl_hazard_ctrl
module tb_pl_hazard_ctrl;

   localparam int MC_LAT = 4;
   // output patterns: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, exmem_bubble, memwb_bubble
   localparam logic [7:0] P_MEM = 8'b1101_0101;
   localparam logic [7:0] P_MC  = 8'b1101_0010;
   localparam logic [7:0] P_FL  = 8'b0010_1000;
   localparam logic [7:0] P_LU  = 8'b1100_1000;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mr;
      logic       mc;
      logic       br;
      logic       mq;
      logic       my;
   } in_t;

   typedef struct packed {
      in_t        i;
      logic [8:0] exp;
   } vec_t;

   localparam in_t IDLE = '0;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;
   vec_t tbl [11];

   always #5 clk = ~clk;

   pl_hazard_ctrl_if #(.REG_W(5)) hz ();

   pl_hazard_ctrl #(.MC_LAT(MC_LAT), .REG_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                              input logic [4:0] rd, input logic mr, input logic mc, input logic br,
                              input logic mq, input logic my);
      in_t v;
      v = '{rs1, rs2, u1, u2, rd, mr, mc, br, mq, my};
      return v;
   endfunction

   task automatic apply(input in_t v);
      hz.id_rs1          = v.rs1;
      hz.id_rs2          = v.rs2;
      hz.id_use_rs1      = v.u1;
      hz.id_use_rs2      = v.u2;
      hz.ex_rd           = v.rd;
      hz.ex_mem_read     = v.mr;
      hz.ex_mc_start     = v.mc;
      hz.ex_branch_taken = v.br;
      hz.mem_req         = v.mq;
      hz.mem_ready       = v.my;
   endtask

   function automatic logic [8:0] outs();
      return {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_stall, hz.idex_bubble,
              hz.exmem_stall, hz.exmem_bubble, hz.memwb_bubble, hz.busy};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input in_t v);
      @(negedge clk);
      apply(v);
      #1;
   endtask

   initial begin
      in_t        v;
      logic [5:0] pc_seq, exb_seq, busy_seq;
      int         n_pc, n_exb, n_mwb;
      int         m_left;
      bit         m_mem, m_pend;
      logic [7:0] p;
      logic       busy, mw, lu;

      tbl[0]  = '{IDLE, 9'b0};
      tbl[1]  = '{mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 0), {P_LU, 1'b0}};
      tbl[2]  = '{IDLE, 9'b0};
      tbl[3]  = '{mk(5'd0, 5'd0, 0, 1, 5'd0, 1, 0, 0, 0, 0), 9'b0};
      tbl[4]  = '{mk(5'd1, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0, 0), {P_LU, 1'b0}};
      tbl[5]  = '{mk(5'd7, 5'd3, 0, 1, 5'd7, 1, 0, 0, 0, 0), 9'b0};
      tbl[6]  = '{mk(5'd7, 5'd0, 1, 0, 5'd7, 0, 0, 0, 0, 0), 9'b0};
      tbl[7]  = '{mk(5'd9, 5'd0, 1, 0, 5'd9, 1, 0, 1, 0, 0), {P_FL, 1'b0}};
      tbl[8]  = '{mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0), {P_FL, 1'b0}};
      tbl[9]  = '{mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1), 9'b0};
      tbl[10] = '{mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0), 9'b0};

      rst = 1'b1;
      apply(IDLE);
      #12;
      chk("reset", outs(), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 11; k++) begin
         cyc(tbl[k].i);
         chk($sformatf("vec%0d", k), outs(), tbl[k].exp);
      end

      // multi-cycle op alone: 4 stall cycles, busy for the 3 after detection
      pc_seq = '0; exb_seq = '0; busy_seq = '0;
      for (int k = 0; k < 6; k++) begin
         v = IDLE;
         v.mc = (k == 0);
         cyc(v);
         pc_seq   = {pc_seq[4:0], hz.pc_stall};
         exb_seq  = {exb_seq[4:0], hz.exmem_bubble};
         busy_seq = {busy_seq[4:0], hz.busy};
      end
      chk("mc_pc_stall", pc_seq, 6'b111100);
      chk("mc_exmem_bubble", exb_seq, 6'b111100);
      chk("mc_busy", busy_seq, 6'b011100);

      // MEM wait with branch held throughout
      v = IDLE; v.mq = 1; v.my = 0; v.br = 1;
      for (int k = 0; k < 3; k++) begin
         cyc(v);
         chk($sformatf("memwait_br%0d", k), outs(), {P_MEM, k != 0});
      end
      v.my = 1;
      cyc(v);
      chk("mem_ready_flush", outs(), {P_FL, 1'b1});
      cyc(IDLE);
      chk("after_mem_run", outs(), 0);

      // branch seen only on the first wait cycle must still flush on release
      v = IDLE; v.mq = 1; v.br = 1;
      cyc(v);
      chk("pend_first", outs(), {P_MEM, 1'b0});
      v.br = 0;
      cyc(v);
      chk("pend_hold", outs(), {P_MEM, 1'b1});
      v.my = 1;
      cyc(v);
      chk("pend_flush", outs(), {P_FL, 1'b1});

      // MEM wait without branch releases with no flush
      v = IDLE; v.mq = 1;
      cyc(v);
      v.my = 1;
      cyc(v);
      chk("mem_release_noflush", outs(), {8'b0, 1'b1});
      cyc(IDLE);
      chk("mem_release_idle", outs(), 0);

      // MEM wait inside MC_WAIT holds the count
      n_pc = 0; n_exb = 0; n_mwb = 0;
      for (int k = 0; k < 10; k++) begin
         v = IDLE;
         v.mc = (k == 0);
         v.mq = (k == 2 || k == 3);
         cyc(v);
         if (k == 2) chk("mc_mem_pattern", outs(), {P_MEM, 1'b1});
         n_pc  += int'(hz.pc_stall);
         n_exb += int'(hz.exmem_bubble);
         n_mwb += int'(hz.memwb_bubble);
      end
      chk("mc_mem_pc_cycles", n_pc, MC_LAT + 2);
      chk("mc_mem_exb_cycles", n_exb, MC_LAT);
      chk("mc_mem_mwb_cycles", n_mwb, 2);

      // asynchronous reset in the middle of MC_WAIT
      v = IDLE; v.mc = 1;
      cyc(v);
      cyc(IDLE);
      chk("pre_rst_mc", outs(), {P_MC, 1'b1});
      #1 rst = 1'b1;
      #1 chk("async_rst", outs(), 0);
      @(negedge clk);
      rst = 1'b0;
      cyc(IDLE);
      chk("post_rst0", outs(), 0);
      cyc(IDLE);
      chk("post_rst1", outs(), 0);

      // randomized traffic against a cycle-level reference
      @(negedge clk);
      rst = 1'b1;
      apply(IDLE);
      @(negedge clk);
      rst = 1'b0;
      m_left = 0; m_mem = 0; m_pend = 0;
      for (int k = 0; k < 600; k++) begin
         v.rs1 = 5'($urandom_range(0, 3));
         v.rs2 = 5'($urandom_range(0, 3));
         v.rd  = 5'($urandom_range(0, 3));
         v.u1  = 1'($urandom_range(0, 1));
         v.u2  = 1'($urandom_range(0, 1));
         v.mr  = 1'($urandom_range(0, 1));
         v.mc  = $urandom_range(0, 9) == 0;
         v.br  = $urandom_range(0, 4) == 0;
         v.mq  = 1'($urandom_range(0, 1));
         v.my  = $urandom_range(0, 2) != 0;
         cyc(v);
         mw   = v.mq && !v.my;
         lu   = v.mr && v.rd != 0 && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
         busy = m_mem || m_left > 0;
         if (m_mem) begin
            if (!v.my) begin
               p = P_MEM;
               m_pend = m_pend || v.br;
            end else begin
               p = (m_pend || v.br) ? P_FL : 8'b0;
               m_pend = 0;
               m_mem = 0;
            end
         end else if (m_left > 0) begin
            if (mw) p = P_MEM;
            else begin
               p = P_MC;
               m_left--;
            end
         end else if (mw) begin
            p = P_MEM;
            m_mem = 1;
            m_pend = v.br;
         end else if (v.mc) begin
            p = P_MC;
            m_left = MC_LAT - 1;
         end else if (v.br) p = P_FL;
         else if (lu) p = P_LU;
         else p = 8'b0;
         chk($sformatf("rand%0d", k), outs(), {p, busy});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
